// File: rtl/ripple_sub_pkg.sv
// Shared constants and FSM state encoding for the bit-serial ripple-borrow subtractor.
package ripple_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : ripple_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/ripple_borrow_subtractor_seq.sv
// Bit-serial A - B - Bin: one bit per cycle LSB first through a single reused full subtractor,
// with a valid/ready request side and a valid/ready result side.
module ripple_borrow_subtractor_seq
    import ripple_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int unsigned     IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] diff_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             borrow_q;
    logic             borrow_d;
    logic             bout_d;
    logic             out_valid_d;
    logic             in_ready_d;
    logic             fs_d;
    logic             fs_bout;

    full_subtractor u_fs (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)           state_d = CALC;
            CALC:    if (idx_q == LAST_IDX)  state_d = DONE;
            DONE:    if (out_ready)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Datapath and output next values; every output is taken from a flop
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = D;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        bout_d      = Bout;
        out_valid_d = out_valid;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    diff_d   = '0;
                    bout_d   = 1'b0;
                    idx_d    = '0;
                end
            end
            CALC: begin
                diff_d[idx_q] = fs_d;
                borrow_d      = fs_bout;
                if (idx_q == LAST_IDX) begin
                    bout_d      = fs_bout;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            borrow_q  <= 1'b0;
            idx_q     <= '0;
            D         <= '0;
            Bout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            borrow_q  <= borrow_d;
            idx_q     <= idx_d;
            D         <= diff_d;
            Bout      <= bout_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule : ripple_borrow_subtractor_seq

// File: tb/tb_ripple_borrow_subtractor_seq.sv
// Directed bench for the bit-serial subtractor: latency, wrap-around, backpressure,
// mid-calculation reset and an exhaustive 4-bit sweep.
module tb_ripple_borrow_subtractor_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       Bin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] D;
    logic       Bout;

    int n_checks = 0;
    int n_fail   = 0;

    ripple_borrow_subtractor_seq #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request/response; stall = cycles out_ready is held low after out_valid rises
    task automatic txn(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic bin, input logic [3:0] exp_d, input logic exp_b,
                       input int stall);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 10) begin
            @(posedge clk); #1; w++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        Bin       = bin;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = ~a;
        B        = ~b;
        Bin      = ~bin;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_d"}, 32'(D), 32'(exp_d));
        check({tag, "_bout"}, 32'(Bout), 32'(exp_b));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            A        = 4'(i * 5 + 3);
            B        = 4'(i * 7 + 1);
            @(posedge clk); #1;
            check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_d"}, 32'(D), 32'(exp_d));
            check({tag, "_hold_b"}, 32'(Bout), 32'(exp_b));
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_done_v"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
        check({tag, "_keep_d"}, 32'(D), 32'(exp_d));
    endtask

    initial begin
        logic [4:0] ref5;
        bit         saw_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_v", 32'(out_valid), 32'd0);
        check("rst_d", 32'(D), 32'd0);
        check("rst_b", 32'(Bout), 32'd0);
        rst_n = 1'b1;

        // Request accepted on the first edge after reset release
        txn("t9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 0);
        txn("t3m9", 4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 0);
        txn("t0m0b", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 0);
        txn("t15m15", 4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 0);
        txn("stall", 4'd12, 4'd5, 1'b1, 4'd6, 1'b0, 3);

        // Reset while bit 2 is being processed
        in_valid = 1'b1;
        A        = 4'd9;
        B        = 4'd3;
        Bin      = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_d", 32'(D), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_d", 32'(D), 32'd0);
        check("mid_rst_b", 32'(Bout), 32'd0);
        check("mid_rst_v", 32'(out_valid), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("no_stale_v", 32'(saw_valid), 32'd0);
        txn("t7m2b", 4'd7, 4'd2, 1'b1, 4'd4, 1'b0, 0);

        // Exhaustive sweep against an arithmetic reference
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    ref5 = 5'(ia) - 5'(ib) - 5'(ic);
                    txn("sweep", 4'(ia), 4'(ib), 1'(ic), ref5[3:0], ref5[4], 0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ripple_borrow_subtractor_seq

// File: doc/ripple_borrow_subtractor_seq.md
RIPPLE_BORROW_SUBTRACTOR_SEQ -- requirements
Module: ripple_borrow_subtractor_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/difference width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: A  input  WIDTH  minuend, sampled on accept.
REQ-007 SHALL have port: B  input  WIDTH  subtrahend, sampled on accept.
REQ-008 SHALL have port: Bin  input  1  borrow-in, sampled on accept.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: D  output  WIDTH  difference A-B-Bin modulo 2^WIDTH.
REQ-012 SHALL have port: Bout  output  1  final borrow-out, 1 when A < B+Bin (unsigned).

Function
REQ-013 SHALL implement FSM with states IDLE, CALC, DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept = in_valid & in_ready.
REQ-015 SHALL on accept latch A, B, Bin into internal registers, clear D, clear bit index, enter CALC.
REQ-016 SHALL in CALC process one bit per cycle, LSB first: bit i uses latched A[i], B[i] and running borrow (initially latched Bin), writes D[i], updates running borrow.
REQ-017 SHALL per-bit: d = a^b^bin; bout = (~a & b) | (~(a^b) & bin).
REQ-018 SHALL after the edge processing bit WIDTH-1 enter DONE, set out_valid=1, Bout=final borrow; out_valid therefore rises exactly WIDTH cycles after the accepting edge.
REQ-019 SHALL hold D, Bout, out_valid stable in DONE while out_ready=0 (backpressure, unbounded).
REQ-020 SHALL on out_valid & out_ready return to IDLE next edge, deassert out_valid; D and Bout retain last values until next accept.
REQ-021 SHALL ignore in_valid, A, B, Bin changes outside IDLE; operand changes after accept do not affect result.
REQ-022 SHALL NOT accept a new request in the same cycle a result is consumed (minimum 1 IDLE cycle between transactions).
REQ-023 SHALL keep bit index width ceil(log2(WIDTH)); index never exceeds WIDTH-1.
REQ-024 SHALL keep D and Bout undriven-by-X: all outputs registered, none combinational from inputs except none (in_ready decoded from state register only).

Reset
REQ-025 SHALL on rst_n=0 immediately, without clock: state=IDLE, in_ready=1, out_valid=0, D=0, Bout=0, bit index=0, latched operands=0.
REQ-026 SHALL on reset mid-CALC or mid-DONE discard the transaction; no out_valid for it after release.
REQ-027 SHALL accept a request on the first rising edge after rst_n deasserts if in_valid=1.

Structure
REQ-028 SHALL place state encoding (IDLE=0, CALC=1, DONE=2, 2-bit) and WIDTH default constant in shared package ripple_sub_pkg.
REQ-029 SHALL instantiate exactly one combinational sub-module full_subtractor (ports a, b, bin, d, bout) for the per-bit step, reused each CALC cycle.
REQ-030 SHALL contain no combinational path from in_valid or out_ready to any output.

Verification
REQ-031 SHALL cover: WIDTH=4, A=9, B=3, Bin=0 -> D=6, Bout=0, out_valid 4 cycles after accept.
REQ-032 SHALL cover: A=3, B=9, Bin=0 -> D=10, Bout=1 (wrap-around).
REQ-033 SHALL cover: A=0, B=0, Bin=1 -> D=15, Bout=1; and A=15, B=15, Bin=0 -> D=0, Bout=0.
REQ-034 SHALL cover: out_ready held 0 for 3 cycles after out_valid -> D/Bout/out_valid stable, in_ready=0, A/B toggled meanwhile without effect.
REQ-035 SHALL cover: rst_n pulsed low at bit 2 of CALC -> outputs zero immediately, in_ready=1, no out_valid; next request A=7,B=2,Bin=1 -> D=4, Bout=0.
REQ-036 SHALL cover: exhaustive 4-bit A×B×Bin back-to-back with out_ready=1 against A-B-Bin reference model.
